// File: rtl/mod47_pkg.sv
// Shared types and helpers for the mod-47 residue datapath.
package mod47_pkg;

  localparam int unsigned MODULUS = 47;
  localparam int unsigned RES_W   = 6;

  typedef logic [RES_W-1:0] residue_t;
  typedef enum logic {IDLE, ACC} acc_state_t;

  localparam residue_t MOD_R = residue_t'(MODULUS);

  // Folds any 6-bit value into 0..46; 47..63 map to 0..16.
  function automatic residue_t reduce6(residue_t v);
    return (v >= MOD_R) ? residue_t'(v - MOD_R) : v;
  endfunction

endpackage

// File: rtl/mod47_add.sv
// Combinational modular adder: y = (a + b) mod 47, with a and b already in 0..46.
module mod47_add
  import mod47_pkg::*;
(
  input  residue_t a,
  input  residue_t b,
  output residue_t y
);

  logic [RES_W:0] sum;
  logic [RES_W:0] mod_w;

  always_comb begin
    mod_w = {1'b0, MOD_R};
    sum   = {1'b0, a} + {1'b0, b};
    if (sum >= mod_w) begin
      y = residue_t'(sum - mod_w);
    end else begin
      y = sum[RES_W-1:0];
    end
  end

endmodule

// File: rtl/mod47_frame_accumulator.sv
// Frame-wise mod-47 accumulator with saturating beat count and registered result slot.
// Optional MOD47_RANGE_CHECK_EN adds out_err, flagging frames that carried any term >= 47.
module mod47_frame_accumulator
  import mod47_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_data,
  output logic [CNT_W-1:0] out_count
`ifdef MOD47_RANGE_CHECK_EN
  ,
  output logic             out_err
`endif
);

  acc_state_t       state;
  residue_t         acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  residue_t         term;
  residue_t         base;
  residue_t         sum;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // IDLE starts a fresh frame, so base and count both come from zero there.
  always_comb begin
    term     = reduce6(in_data);
    base     = (state == ACC) ? acc : '0;
    base_cnt = (state == ACC) ? cnt : '0;
    cnt_inc  = (base_cnt == '1) ? base_cnt : base_cnt + 1'b1;
  end

  mod47_add u_add (
    .a (base),
    .b (term),
    .y (sum)
  );

`ifdef MOD47_RANGE_CHECK_EN
  logic err_flag;
  logic err_next;

  always_comb begin
    err_next = ((state == ACC) ? err_flag : 1'b0) || (in_data >= MOD_R);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      out_err  <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        err_flag <= 1'b0;
        out_err  <= err_next;
      end else begin
        err_flag <= err_next;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      // A publish in the drain cycle keeps out_valid high with the new result.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          out_valid <= 1'b1;
          out_data  <= sum;
          out_count <= cnt_inc;
          acc       <= '0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          acc       <= sum;
          cnt       <= cnt_inc;
          state     <= ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod47_frame_accumulator.sv
// Directed, table-driven bench for mod47_frame_accumulator (default and MOD47_RANGE_CHECK_EN builds).
module tb_mod47_frame_accumulator;

  localparam int unsigned CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_data;
  logic [CNT_W-1:0] out_count;
`ifdef MOD47_RANGE_CHECK_EN
  logic             out_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod47_frame_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef MOD47_RANGE_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  typedef struct {
    int          n;
    logic [5:0]  d [4];
    logic [5:0]  exp_data;
    int          exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one beat starting just after a rising edge; returns after it is accepted.
  task automatic beat(input logic [5:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int d, input int c, input logic e);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"},  int'(out_data), d);
    chk({tag, "_count"}, int'(out_count), c);
`ifdef MOD47_RANGE_CHECK_EN
    chk({tag, "_err"},   int'(out_err), int'(e));
`else
    if (e === 1'bx) chk({tag, "_err_x"}, 0, 1);
`endif
  endtask

  function automatic vec_t mk(int n, int a, int b, int c, int xd, int xc, logic xe);
    vec_t v;
    v.n = n;
    v.d[0] = 6'(a); v.d[1] = 6'(b); v.d[2] = 6'(c); v.d[3] = '0;
    v.exp_data = 6'(xd);
    v.exp_cnt  = xc;
    v.exp_err  = xe;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(2, 46, 1,  0,  0, 2, 1'b0);
    vecs[1] = mk(3, 30, 20, 10, 13, 3, 1'b0);
    vecs[2] = mk(1, 63, 0,  0,  16, 1, 1'b1);
    vecs[3] = mk(1, 47, 0,  0,  0,  1, 1'b1);
    vecs[4] = mk(1, 0,  0,  0,  0,  1, 1'b0);
    vecs[5] = mk(2, 46, 46, 0,  45, 2, 1'b0);
    vecs[6] = mk(3, 63, 63, 63, 1,  3, 1'b1);
    vecs[7] = mk(3, 45, 1,  0,  46, 3, 1'b0);
    vecs[8] = mk(2, 62, 2,  0,  17, 2, 1'b1);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      for (int b = 0; b < vecs[i].n; b++) begin
        beat(vecs[i].d[b], b == vecs[i].n - 1);
        if (b < vecs[i].n - 1) chk($sformatf("vec%0d_midframe_valid", i), int'(out_valid), 0);
      end
      check_result($sformatf("vec%0d", i), int'(vecs[i].exp_data), vecs[i].exp_cnt, vecs[i].exp_err);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drained", i), int'(out_valid), 0);
    end

    // 500 beats of 1: 500 mod 47 = 30.
    for (int b = 0; b < 500; b++) beat(6'd1, b == 499);
    check_result("long500", 30, 500, 1'b0);
    @(posedge clk); #1;

    // 1030 beats of 1: count saturates at 1023, residue 1030 mod 47 = 43.
    for (int b = 0; b < 1030; b++) beat(6'd1, b == 1029);
    check_result("sat1030", 43, 1023, 1'b0);
    @(posedge clk); #1;

    // Backpressure: hold a result, offer a second frame, then release.
    out_ready = 1'b0;
    beat(6'd7, 1'b1);
    check_result("bp_first", 7, 1, 1'b0);
    in_valid = 1'b1; in_data = 6'd5; in_last = 1'b1;
    #1;
    chk("bp_in_ready_low", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_in_ready_still_low", int'(in_ready), 0);
    check_result("bp_held", 7, 1, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check_result("bp_second", 5, 1, 1'b0);
    @(posedge clk); #1;
    chk("bp_drained", int'(out_valid), 0);

    // Reset mid-frame discards the partial sum.
    beat(6'd10, 1'b0);
    beat(6'd10, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_count", int'(out_count), 0);
    rst = 1'b0;
    beat(6'd3, 1'b1);
    check_result("after_rst", 3, 1, 1'b0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
